// File: rtl/elevator_pkg.sv
// Shared types and encodings for the elevator dispatch controller.
//   slot_st_e : state of one trip slot (FREE / WAIT / RIDE)
//   fsm_st_e  : car scheduler state (IDLE / MOVE / DOOR)
//   DIR_*     : ev_dir output encodings
package elevator_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_WAIT = 2'd1,
        SLOT_RIDE = 2'd2
    } slot_st_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } fsm_st_e;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    function automatic logic [1:0] dir_code(input logic moving, input logic up);
        if (!moving) return DIR_STOP;
        return up ? DIR_UP : DIR_DOWN;
    endfunction

endpackage

// File: rtl/elevator_dispatch_ctrl_if.sv
// Request / car-status bundle between the hall/car front-end and the
// dispatch controller.
//   master : front-end side, drives req_valid/req_src/req_dest/req_dir
//   slave  : controller side, drives req_ready/req_err, ev_floor/ev_dir/
//            ev_door, busy, done_valid/done_slot
interface elevator_dispatch_ctrl_if #(
    parameter int FLOOR_W = 3,
    parameter int SLOT_W  = 2
);
    logic               req_valid;
    logic               req_ready;
    logic [FLOOR_W-1:0] req_src;
    logic [FLOOR_W-1:0] req_dest;
    logic               req_dir;
    logic               req_err;
    logic [FLOOR_W-1:0] ev_floor;
    logic [1:0]         ev_dir;
    logic               ev_door;
    logic               busy;
    logic               done_valid;
    logic [SLOT_W-1:0]  done_slot;

    modport master (
        output req_valid, req_src, req_dest, req_dir,
        input  req_ready, req_err, ev_floor, ev_dir, ev_door, busy,
               done_valid, done_slot
    );

    modport slave (
        input  req_valid, req_src, req_dest, req_dir,
        output req_ready, req_err, ev_floor, ev_dir, ev_door, busy,
               done_valid, done_slot
    );
endinterface

// File: rtl/elevator_dispatch_ctrl_car_motion.sv
// Car model: floor register, per-floor travel timer and door dwell timer.
//   clk, rst_n  : clock, synchronous active-low reset
//   move_req    : car is travelling; timer runs while high
//   dir_up      : travel direction for the current floor step
//   door_req    : one-cycle pulse, opens the door for DOOR_CYCLES cycles
//   floor       : current floor
//   next_floor  : floor the car holds after this edge (differs on arrive)
//   arrive      : last cycle of a floor step; floor changes at this edge
//   door_open   : door is open
//   door_done   : last open cycle of the door
module car_motion #(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_W     = 3,
    parameter int MOVE_CYCLES = 10,
    parameter int DOOR_CYCLES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               move_req,
    input  logic               dir_up,
    input  logic               door_req,
    output logic [FLOOR_W-1:0] floor,
    output logic [FLOOR_W-1:0] next_floor,
    output logic               arrive,
    output logic               door_open,
    output logic               door_done
);
    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [MW-1:0]      MOVE_LOAD = MW'(MOVE_CYCLES);
    localparam logic [DW-1:0]      DOOR_LOAD = DW'(DOOR_CYCLES);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    logic [MW-1:0]      move_cnt_q, move_cnt_d, move_rem;
    logic [DW-1:0]      door_cnt_q, door_cnt_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;

    // A zero move count means "no step in progress"; the first travelling
    // cycle behaves as if the counter had just been loaded.
    always_comb begin
        move_rem   = (move_cnt_q == '0) ? MOVE_LOAD : move_cnt_q;
        arrive     = move_req && (move_rem == MW'(1));
        move_cnt_d = '0;
        if (move_req && !arrive) move_cnt_d = move_rem - MW'(1);

        floor_d = floor_q;
        if (arrive) begin
            if (dir_up) begin
                if (floor_q != TOP_FLOOR) floor_d = floor_q + FLOOR_W'(1);
            end else begin
                if (floor_q != '0) floor_d = floor_q - FLOOR_W'(1);
            end
        end

        door_open  = (door_cnt_q != '0);
        door_done  = (door_cnt_q == DW'(1));
        door_cnt_d = '0;
        if (door_req)       door_cnt_d = DOOR_LOAD;
        else if (door_open) door_cnt_d = door_cnt_q - DW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            move_cnt_q <= '0;
            door_cnt_q <= '0;
            floor_q    <= '0;
        end else begin
            move_cnt_q <= move_cnt_d;
            door_cnt_q <= door_cnt_d;
            floor_q    <= floor_d;
        end
    end

    assign floor      = floor_q;
    assign next_floor = floor_d;

endmodule

// File: rtl/elevator_dispatch_ctrl.sv
// Directional-collective (SCAN) elevator dispatcher with NUM_SLOTS trip slots.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of elevator_dispatch_ctrl_if (trip requests in,
//                car floor/direction/door, busy and trip-done pulses out)
//
//   state | meaning
//   IDLE  | no travel; waits for a stop, opens here or picks nearest direction
//   MOVE  | travelling one floor per MOVE_CYCLES in dir_up_q
//   DOOR  | door open DOOR_CYCLES; afterwards continue, reverse or idle
module elevator_dispatch_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_W     = 3,
    parameter int NUM_SLOTS   = 4,
    parameter int MOVE_CYCLES = 10,
    parameter int DOOR_CYCLES = 30
) (
    input  logic                    clk,
    input  logic                    rst_n,
    elevator_dispatch_ctrl_if.slave bus
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int NF_PAD = 1 << FLOOR_W;

    slot_st_e           slot_q [NUM_SLOTS];
    slot_st_e           slot_d [NUM_SLOTS];
    logic [FLOOR_W-1:0] src_q  [NUM_SLOTS];
    logic [FLOOR_W-1:0] src_d  [NUM_SLOTS];
    logic [FLOOR_W-1:0] dest_q [NUM_SLOTS];
    logic [FLOOR_W-1:0] dest_d [NUM_SLOTS];

    fsm_st_e               state_q, state_d;
    logic                  dir_up_q, dir_up_d;
    logic [NUM_SLOTS-1:0]  pend_q, pend_d, pend_all, new_done, alloc_oh;
    logic                  done_valid_q, done_valid_d;
    logic [SLOT_W-1:0]     done_slot_q, done_slot_d;
    logic                  req_err_q, req_err_d;

    logic [NF_PAD-1:0]  stop_mask;
    logic               any_free, any_busy, req_ok, accept, found;
    logic               stops_up, stops_dn, choose_up, here, ahead, behind;
    int                 dist_up, dist_dn;
    logic               open_now, move_req, door_req;
    logic [FLOOR_W-1:0] cur_floor, eval_floor;
    logic               arrive, door_open, door_done;

    car_motion #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W),
        .MOVE_CYCLES(MOVE_CYCLES),
        .DOOR_CYCLES(DOOR_CYCLES)
    ) u_car (
        .clk       (clk),
        .rst_n     (rst_n),
        .move_req  (move_req),
        .dir_up    (dir_up_q),
        .door_req  (door_req),
        .floor     (cur_floor),
        .next_floor(eval_floor),
        .arrive    (arrive),
        .door_open (door_open),
        .door_done (door_done)
    );

    assign move_req = (state_q == ST_MOVE);

    always_comb begin
        stop_mask = '0;
        any_free  = 1'b0;
        any_busy  = 1'b0;
        alloc_oh  = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (slot_q[s] == SLOT_WAIT) stop_mask[src_q[s]]  = 1'b1;
            if (slot_q[s] == SLOT_RIDE) stop_mask[dest_q[s]] = 1'b1;
            if (slot_q[s] == SLOT_FREE) begin
                if (!any_free) alloc_oh[s] = 1'b1;
                any_free = 1'b1;
            end else begin
                any_busy = 1'b1;
            end
        end
    end

    // Stops strictly above/below the floor being evaluated (the arrival
    // floor during an arrive cycle, otherwise the current floor).
    always_comb begin
        stops_up = 1'b0;
        stops_dn = 1'b0;
        dist_up  = NF_PAD;
        dist_dn  = NF_PAD;
        for (int f = 0; f < NF_PAD; f++) begin
            if (stop_mask[f]) begin
                if (f > int'(eval_floor)) begin
                    if (!stops_up) dist_up = f - int'(eval_floor);
                    stops_up = 1'b1;
                end else if (f < int'(eval_floor)) begin
                    dist_dn  = int'(eval_floor) - f;
                    stops_dn = 1'b1;
                end
            end
        end
        choose_up = stops_up && (!stops_dn || (dist_up <= dist_dn));
    end

    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        door_req = 1'b0;
        open_now = 1'b0;
        here     = stop_mask[eval_floor];
        ahead    = dir_up_q ? stops_up : stops_dn;
        behind   = dir_up_q ? stops_dn : stops_up;
        case (state_q)
            ST_IDLE: begin
                if (here) begin
                    state_d  = ST_DOOR;
                    door_req = 1'b1;
                    open_now = 1'b1;
                end else if (stops_up || stops_dn) begin
                    state_d  = ST_MOVE;
                    dir_up_d = choose_up;
                end
            end
            ST_MOVE: begin
                if (arrive) begin
                    if (here) begin
                        state_d  = ST_DOOR;
                        door_req = 1'b1;
                        open_now = 1'b1;
                    end else if (!ahead) begin
                        if (behind) dir_up_d = !dir_up_q;
                        else        state_d  = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                if (door_done) begin
                    if (ahead) begin
                        state_d = ST_MOVE;
                    end else if (behind) begin
                        state_d  = ST_MOVE;
                        dir_up_d = !dir_up_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ok = (bus.req_src != bus.req_dest)
              && (32'(bus.req_src)  < NUM_FLOORS)
              && (32'(bus.req_dest) < NUM_FLOORS)
              && (bus.req_dir ? (bus.req_src < bus.req_dest)
                              : (bus.req_src > bus.req_dest));
        accept = bus.req_valid && any_free;
    end

    // Slot updates happen on the edge the door opens; a slot accepted on
    // that same edge only becomes WAIT afterwards and waits for a later stop.
    always_comb begin
        slot_d    = slot_q;
        src_d     = src_q;
        dest_d    = dest_q;
        new_done  = '0;
        req_err_d = accept && !req_ok;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (open_now) begin
                if (slot_q[s] == SLOT_WAIT && src_q[s] == eval_floor) begin
                    slot_d[s] = SLOT_RIDE;
                end else if (slot_q[s] == SLOT_RIDE && dest_q[s] == eval_floor) begin
                    slot_d[s]   = SLOT_FREE;
                    new_done[s] = 1'b1;
                end
            end
            if (accept && req_ok && alloc_oh[s]) begin
                slot_d[s] = SLOT_WAIT;
                src_d[s]  = bus.req_src;
                dest_d[s] = bus.req_dest;
            end
        end
    end

    // Completions from one stop drain one per cycle, lowest slot first.
    always_comb begin
        pend_all     = pend_q | new_done;
        pend_d       = pend_all;
        done_valid_d = 1'b0;
        done_slot_d  = '0;
        found        = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (pend_all[s] && !found) begin
                found        = 1'b1;
                done_valid_d = 1'b1;
                done_slot_d  = SLOT_W'(s);
                pend_d[s]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dir_up_q     <= 1'b1;
            pend_q       <= '0;
            done_valid_q <= 1'b0;
            done_slot_q  <= '0;
            req_err_q    <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_q[s] <= SLOT_FREE;
                src_q[s]  <= '0;
                dest_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            dir_up_q     <= dir_up_d;
            pend_q       <= pend_d;
            done_valid_q <= done_valid_d;
            done_slot_q  <= done_slot_d;
            req_err_q    <= req_err_d;
            slot_q       <= slot_d;
            src_q        <= src_d;
            dest_q       <= dest_d;
        end
    end

    assign bus.req_ready  = any_free;
    assign bus.req_err    = req_err_q;
    assign bus.ev_floor   = cur_floor;
    assign bus.ev_dir     = dir_code(state_q == ST_MOVE, dir_up_q);
    assign bus.ev_door    = door_open;
    assign bus.busy       = any_busy;
    assign bus.done_valid = done_valid_q;
    assign bus.done_slot  = done_slot_q;

endmodule

// File: tb/tb_elevator_dispatch_ctrl.sv
// Scoreboard bench for elevator_dispatch_ctrl: expected stop floors and trip
// completions are queued as trips are issued and checked by a monitor.
module tb_elevator_dispatch_ctrl;
    localparam int NUM_FLOORS  = 7;
    localparam int FLOOR_W     = 3;
    localparam int NUM_SLOTS   = 2;
    localparam int SLOT_W      = 1;
    localparam int MOVE_CYCLES = 2;
    localparam int DOOR_CYCLES = 3;

    typedef struct {
        int slot;
        int floor;
    } done_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   t_acc;
    int   door_len;
    logic door_prev;

    done_t exp_done[$];
    int    exp_stop[$];

    elevator_dispatch_ctrl_if #(.FLOOR_W(FLOOR_W), .SLOT_W(SLOT_W)) bus();

    elevator_dispatch_ctrl #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W),
        .NUM_SLOTS  (NUM_SLOTS),
        .MOVE_CYCLES(MOVE_CYCLES),
        .DOOR_CYCLES(DOOR_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void exp_trip_done(input int slot, input int floor);
        done_t d;
        d.slot  = slot;
        d.floor = floor;
        exp_done.push_back(d);
    endfunction

    // Monitor: every door opening must be the next expected stop, every door
    // episode lasts DOOR_CYCLES, every done pulse is the next expected trip.
    always @(negedge clk) begin
        if (!rst_n) begin
            door_prev = 1'b0;
            door_len  = 0;
        end else begin
            if (bus.ev_door) door_len++;
            if (bus.ev_door && !door_prev) begin
                if (exp_stop.size() == 0) chk("stop_unexpected", int'(bus.ev_floor), -1);
                else                      chk("stop_floor", int'(bus.ev_floor), exp_stop.pop_front());
            end
            if (!bus.ev_door && door_prev) begin
                chk("door_len", door_len, DOOR_CYCLES);
                door_len = 0;
            end
            if (bus.done_valid) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", int'(bus.done_slot), -1);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("done_slot", int'(bus.done_slot), d.slot);
                    chk("done_floor", int'(bus.ev_floor), d.floor);
                    chk("done_door", int'(bus.ev_door), 1);
                end
            end
            door_prev = bus.ev_door;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_done.delete();
        exp_stop.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_floor", int'(bus.ev_floor), 0);
        chk("rst_dir", int'(bus.ev_dir), 0);
        chk("rst_door", int'(bus.ev_door), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_err", int'(bus.req_err), 0);
        chk("rst_done", int'(bus.done_valid), 0);
        rst_n = 1'b1;
    endtask

    task automatic send(input int src, input int dest, input bit dir);
        logic [31:0] s, d;
        s = src;
        d = dest;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_src   = s[FLOOR_W-1:0];
        bus.req_dest  = d[FLOOR_W-1:0];
        bus.req_dir   = dir;
        @(posedge clk);
        #1;
        t_acc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_done.size() != 0 || bus.busy || bus.ev_door) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_left"}, exp_done.size(), 0);
        chk({name, "_stop_left"}, exp_stop.size(), 0);
        chk({name, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        cyc   = 0;
        bus.req_valid = 1'b0;
        bus.req_src   = '0;
        bus.req_dest  = '0;
        bus.req_dir   = 1'b0;

        // Single trip 3->5: timing of departure, door and completion.
        do_reset();
        exp_stop = '{3, 5};
        exp_trip_done(0, 5);
        send(3, 5, 1'b1);
        @(negedge clk);
        chk("t1_dir_idle", int'(bus.ev_dir), 0);
        @(negedge clk);
        chk("t1_dir_up", int'(bus.ev_dir), 1);
        n = 0;
        while (!bus.ev_door && n < 100) begin @(negedge clk); n++; end
        chk("t1_open_cyc", cyc - t_acc, 7);
        chk("t1_open_dir", int'(bus.ev_dir), 0);
        n = 0;
        while (!bus.done_valid && n < 100) begin @(negedge clk); n++; end
        chk("t1_done_cyc", cyc - t_acc, 14);
        drain("t1");

        // Invalid requests: error pulse, nothing stored.
        do_reset();
        begin
            int bad_req [4][3];
            bad_req = '{'{2, 2, 1}, '{5, 1, 1}, '{1, 4, 0}, '{7, 0, 0}};
            for (int i = 0; i < 4; i++) begin
                send(bad_req[i][0], bad_req[i][1], bad_req[i][2] != 0);
                @(negedge clk);
                chk("inv_err", int'(bus.req_err), 1);
                chk("inv_busy", int'(bus.busy), 0);
                @(negedge clk);
                chk("inv_err_clr", int'(bus.req_err), 0);
            end
        end

        // Two up trips: 1->6 and 3->4.
        do_reset();
        exp_stop = '{1, 3, 4, 6};
        exp_trip_done(1, 4);
        exp_trip_done(0, 6);
        send(1, 6, 1'b1);
        send(3, 4, 1'b1);
        drain("t3");

        // Full slots: third request ignored until a slot frees.
        do_reset();
        exp_stop = '{2, 3, 4, 6};
        exp_trip_done(0, 3);
        exp_trip_done(1, 6);
        send(2, 3, 1'b1);
        send(4, 6, 1'b1);
        @(negedge clk);
        chk("full_ready", int'(bus.req_ready), 0);
        bus.req_valid = 1'b1;
        bus.req_src   = 3'd0;
        bus.req_dest  = 3'd5;
        bus.req_dir   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_no_err", int'(bus.req_err), 0);
        end
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.done_valid && n < 200) begin @(negedge clk); n++; end
        chk("full_ready_back", int'(bus.req_ready), 1);
        drain("t4");

        // Mixed directions: 5->2 down and 1->3 up.
        do_reset();
        exp_stop = '{1, 3, 5, 2};
        exp_trip_done(1, 3);
        exp_trip_done(0, 2);
        send(5, 2, 1'b0);
        send(1, 3, 1'b1);
        drain("t5");

        // Reset while travelling between floors 2 and 3.
        do_reset();
        exp_stop = '{5};
        exp_trip_done(0, 6);
        send(5, 6, 1'b1);
        n = 0;
        while (bus.ev_floor != 3'd2 && n < 100) begin @(negedge clk); n++; end
        chk("t6_at2", int'(bus.ev_floor), 2);
        do_reset();
        repeat (30) @(negedge clk);
        chk("t6_floor", int'(bus.ev_floor), 0);
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_door", int'(bus.ev_door), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
